// File: rtl/crc32_pkg.sv
// Shared types and constants for the serial CRC-32 frame controller.
package crc32_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = $clog2(BYTE_W);

    localparam logic [31:0] DEF_POLY = 32'h04C11DB7;
    localparam logic [31:0] DEF_INIT = 32'hFFFFFFFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // One MSB-first CRC step: no reflection, no final XOR.
    function automatic logic [31:0] crc_step(
        input logic [31:0] crc,
        input logic        bit_in,
        input logic [31:0] poly
    );
        logic fb;
        fb = crc[31] ^ bit_in;
        return {crc[30:0], 1'b0} ^ (fb ? poly : '0);
    endfunction

endpackage

// File: rtl/crc32_serial_core.sv
// Bit-serial 32-bit CRC register: one polynomial step per enabled cycle.
module crc32_serial_core
    import crc32_pkg::*;
#(
    parameter logic [31:0] POLY = DEF_POLY,
    parameter logic [31:0] INIT = DEF_INIT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        step_en,
    input  logic        bit_in,
    output logic [31:0] crc
);

    // CRC register: clear (reload INIT) has priority over a step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc <= INIT;
        end else if (clear) begin
            crc <= INIT;
        end else if (step_en) begin
            crc <= crc_step(crc, bit_in, POLY);
        end
    end

endmodule

// File: rtl/crc32_frame_ctrl.sv
// Frame controller: accepts bytes, serializes them MSB first into the CRC
// core and presents the frame CRC with a valid/ready handshake.
module crc32_frame_ctrl
    import crc32_pkg::*;
#(
    parameter logic [31:0] POLY = DEF_POLY,
    parameter logic [31:0] INIT = DEF_INIT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              abort,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [BYTE_W-1:0] s_data,
    input  logic              s_last,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [31:0]       m_crc,
    output logic              busy
);

    state_t             state;
    logic [BYTE_W-1:0]  sreg;
    logic [CNT_W-1:0]   bit_cnt;
    logic               last_q;
    logic               last_bit;
    logic               xfer;
    logic               crc_clear;
    logic               crc_step_en;
    logic [31:0]        crc;

    assign last_bit = (bit_cnt == CNT_W'(BYTE_W - 1));

    // Byte acceptance: free in IDLE, or on the final bit of a non-last byte
    // so a continuous stream runs at 8 cycles/byte with no bubble.
    always_comb begin
        s_ready = 1'b0;
        if (!abort) begin
            case (state)
                IDLE:    s_ready = 1'b1;
                SHIFT:   s_ready = last_bit && !last_q;
                default: s_ready = 1'b0;
            endcase
        end
    end

    assign xfer        = s_valid && s_ready;
    assign crc_clear   = abort || ((state == DONE) && m_ready);
    assign crc_step_en = (state == SHIFT);
    assign m_crc       = crc;

    crc32_serial_core #(
        .POLY (POLY),
        .INIT (INIT)
    ) u_core (
        .clk     (clk),
        .rst     (rst),
        .clear   (crc_clear),
        .step_en (crc_step_en),
        .bit_in  (sreg[BYTE_W-1]),
        .crc     (crc)
    );

    // Frame FSM with serializer, bit counter and registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            sreg    <= '0;
            bit_cnt <= '0;
            last_q  <= 1'b0;
            m_valid <= 1'b0;
            busy    <= 1'b0;
        end else if (abort) begin
            state   <= IDLE;
            bit_cnt <= '0;
            last_q  <= 1'b0;
            m_valid <= 1'b0;
            busy    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (xfer) begin
                        sreg    <= s_data;
                        last_q  <= s_last;
                        bit_cnt <= '0;
                        state   <= SHIFT;
                        busy    <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (xfer) begin
                        sreg    <= s_data;
                        last_q  <= s_last;
                        bit_cnt <= '0;
                    end else if (last_bit) begin
                        bit_cnt <= '0;
                        if (last_q) begin
                            state   <= DONE;
                            m_valid <= 1'b1;
                        end else begin
                            // Mid-frame stall: CRC register is kept for the next byte.
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        sreg    <= {sreg[BYTE_W-2:0], 1'b0};
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (m_ready) begin
                        state   <= IDLE;
                        m_valid <= 1'b0;
                        busy    <= 1'b0;
                        last_q  <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    m_valid <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_crc32_frame_ctrl.sv
// Directed testbench for crc32_frame_ctrl using the "123456789" check vector.
module tb_crc32_frame_ctrl;

    localparam logic [31:0] CHECK_CRC = 32'h0376E6E7;
    localparam logic [31:0] INIT_VAL  = 32'hFFFFFFFF;

    logic        clk = 1'b0;
    logic        rst;
    logic        abort;
    logic        s_valid;
    logic        s_ready;
    logic [7:0]  s_data;
    logic        s_last;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_crc;
    logic        busy;

    int unsigned n_checks   = 0;
    int unsigned n_pass     = 0;
    int unsigned cyc        = 0;
    int unsigned rise_cnt   = 0;
    int unsigned rise_cyc   = 0;
    int unsigned xfer_cyc   = 0;
    int unsigned first_xfer = 0;
    int unsigned last_xfer  = 0;
    int unsigned base;
    int unsigned r0;
    int unsigned nw;
    logic        mv_prev    = 1'b0;
    logic [31:0] res_q[$];

    crc32_frame_ctrl #(
        .POLY (32'h04C11DB7),
        .INIT (32'hFFFFFFFF)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .abort   (abort),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .s_last  (s_last),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_crc   (m_crc),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    // Posedge counter used for latency measurements.
    always @(posedge clk) cyc <= cyc + 1;

    // Result monitor, sampled mid low phase after inputs have settled.
    always begin
        @(negedge clk);
        #3;
        if (m_valid && !mv_prev) begin
            rise_cnt++;
            rise_cyc = cyc;
        end
        if (m_valid && m_ready && !rst && !abort) res_q.push_back(m_crc);
        mv_prev = m_valid;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got %0d/%0d", n_pass, n_checks);
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    endtask

    // Present one byte from a negedge and hold it until it is taken.
    task automatic send_byte(input logic [7:0] d, input logic l);
        int unsigned n = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        #1;
        while (!s_ready && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!s_ready) check("xfer_wait", {31'b0, s_ready}, 32'd1);
        else begin
            xfer_cyc = cyc + 1;
            @(negedge clk);
        end
    endtask

    task automatic send_frame(input int unsigned gap);
        for (int unsigned i = 0; i < 9; i++) begin
            send_byte(8'h31 + 8'(i), i == 8);
            if (i == 0) first_xfer = xfer_cyc;
            if (i == 8) last_xfer = xfer_cyc;
            if (gap != 0 && i != 8) begin
                int unsigned n = 0;
                s_valid = 1'b0;
                while (busy && n < 20) begin
                    @(negedge clk);
                    n++;
                end
                check("busy_len", n, 32'd8);
                for (int unsigned g = 0; g < gap; g++) begin
                    check("gap_ready", {31'b0, s_ready}, 32'd1);
                    check("gap_busy", {31'b0, busy}, 32'd0);
                    @(negedge clk);
                end
            end
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_result(input int unsigned want);
        int unsigned n = 0;
        while (res_q.size() < want && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("result_count", res_q.size(), want);
    endtask

    task automatic wait_mvalid();
        int unsigned n = 0;
        while (!m_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("mvalid_up", {31'b0, m_valid}, 32'd1);
    endtask

    initial begin
        rst = 1'b1; abort = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_sready", {31'b0, s_ready}, 32'd1);
        check("rst_mvalid", {31'b0, m_valid}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_crc", m_crc, INIT_VAL);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_sready", {31'b0, s_ready}, 32'd1);
        check("post_rst_busy", {31'b0, busy}, 32'd0);
        check("post_rst_crc", m_crc, INIT_VAL);

        // Sustained frame, consumer always ready.
        base = res_q.size(); r0 = rise_cnt;
        send_frame(0);
        check("t1_no_bubble", last_xfer - first_xfer, 32'd64);
        wait_result(base + 1);
        if (res_q.size() > base) check("t1_crc", res_q[base], CHECK_CRC);
        check("t1_latency", rise_cyc - first_xfer, 32'd72);
        check("t1_last_latency", rise_cyc - last_xfer, 32'd8);
        check("t1_pulse", {31'b0, m_valid}, 32'd0);
        check("t1_crc_init", m_crc, INIT_VAL);
        check("t1_rises", rise_cnt - r0, 32'd1);

        // Gapped frame: controller idles between bytes with CRC retained.
        base = res_q.size();
        send_frame(3);
        wait_result(base + 1);
        if (res_q.size() > base) check("t2_crc", res_q[base], CHECK_CRC);
        check("t2_busy_after", {31'b0, busy}, 32'd0);

        // Result backpressure, with a byte offered while DONE.
        m_ready = 1'b0;
        base = res_q.size();
        send_frame(0);
        wait_mvalid();
        s_valid = 1'b1; s_data = 8'hAA; s_last = 1'b1;
        for (int unsigned k = 0; k < 20; k++) begin
            check("t3_hold_mvalid", {31'b0, m_valid}, 32'd1);
            check("t3_hold_crc", m_crc, CHECK_CRC);
            check("t3_hold_sready", {31'b0, s_ready}, 32'd0);
            @(negedge clk);
        end
        s_valid = 1'b0; s_last = 1'b0;
        m_ready = 1'b1;
        @(negedge clk);
        check("t3_release_mvalid", {31'b0, m_valid}, 32'd0);
        check("t3_release_crc", m_crc, INIT_VAL);
        check("t3_release_busy", {31'b0, busy}, 32'd0);
        check("t3_count", res_q.size(), base + 1);
        if (res_q.size() > base) check("t3_crc", res_q[base], CHECK_CRC);
        base = res_q.size();
        send_frame(0);
        wait_result(base + 1);
        if (res_q.size() > base) check("t3_next_crc", res_q[base], CHECK_CRC);

        // Abort after 0x34, with a byte offered during abort.
        base = res_q.size(); r0 = rise_cnt;
        for (int unsigned i = 0; i < 4; i++) send_byte(8'h31 + 8'(i), 1'b0);
        abort = 1'b1; s_valid = 1'b1; s_data = 8'h35; s_last = 1'b0;
        #1;
        check("ab_sready", {31'b0, s_ready}, 32'd0);
        @(negedge clk);
        check("ab_busy", {31'b0, busy}, 32'd0);
        check("ab_mvalid", {31'b0, m_valid}, 32'd0);
        check("ab_crc", m_crc, INIT_VAL);
        abort = 1'b0; s_valid = 1'b0;
        #1;
        check("ab_sready_after", {31'b0, s_ready}, 32'd1);
        @(negedge clk);
        abort = 1'b1; s_valid = 1'b1; s_data = 8'h31;
        #1;
        check("ab_idle_sready", {31'b0, s_ready}, 32'd0);
        @(negedge clk);
        check("ab_idle_busy", {31'b0, busy}, 32'd0);
        abort = 1'b0; s_valid = 1'b0;
        repeat (10) @(negedge clk);
        check("ab_no_rise", rise_cnt - r0, 32'd0);
        check("ab_no_result", res_q.size(), base);
        send_frame(0);
        wait_result(base + 1);
        if (res_q.size() > base) check("ab_next_crc", res_q[base], CHECK_CRC);

        // Asynchronous reset pulse mid-SHIFT.
        base = res_q.size();
        send_byte(8'h31, 1'b0);
        send_byte(8'h32, 1'b0);
        s_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("arst_sready", {31'b0, s_ready}, 32'd1);
        check("arst_busy", {31'b0, busy}, 32'd0);
        check("arst_mvalid", {31'b0, m_valid}, 32'd0);
        check("arst_crc", m_crc, INIT_VAL);
        #1 rst = 1'b0;
        @(negedge clk);

        // Asynchronous reset pulse while a result is pending.
        m_ready = 1'b0;
        send_frame(0);
        wait_mvalid();
        #2 rst = 1'b1;
        #1;
        check("drst_mvalid", {31'b0, m_valid}, 32'd0);
        check("drst_busy", {31'b0, busy}, 32'd0);
        check("drst_crc", m_crc, INIT_VAL);
        #1 rst = 1'b0;
        m_ready = 1'b1;
        repeat (5) @(negedge clk);
        check("drst_no_result", res_q.size(), base);
        send_frame(0);
        wait_result(base + 1);
        if (res_q.size() > base) check("arst_next_crc", res_q[base], CHECK_CRC);

        // Back-to-back frames.
        base = res_q.size();
        send_frame(0);
        send_frame(0);
        wait_result(base + 2);
        if (res_q.size() > base) check("b2b_crc0", res_q[base], CHECK_CRC);
        if (res_q.size() > base + 1) check("b2b_crc1", res_q[base + 1], CHECK_CRC);

        nw = 0;
        while (busy && nw < 50) begin
            @(negedge clk);
            nw++;
        end
        check("final_idle", {31'b0, busy}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
